irq_controller: RTL and testbench

- Memory-mapped interrupt controller on the shared 8-bit CPU bus.
- Collects interrupt requests from up to 8 peripherals (Timer, Mouse, VGA, ...) and latches them as pending.
- Applies a software mask and fixed priority, then presents one combined request to a single CPU interrupt line.
- Routes the CPU acknowledge back to the winning peripheral and exposes the winner's ID plus an end-of-interrupt (EOI) register so the CPU can sequence service.

---
 rtl/irq_controller_if.sv | 22 ++
 rtl/irq_controller.sv | 139 +++++++++++++
 tb/tb_irq_controller.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/irq_controller_if.sv
// CPU-side address/control and peripheral request/acknowledge lines of the interrupt controller.
// The shared data bus is tristate and therefore stays a plain inout port on the controller.
interface irq_controller_if #(
    parameter int NUM_SRC = 4
) ();
    logic [7:0]         bus_addr;
    logic               bus_we;
    logic [NUM_SRC-1:0] src_irq;
    logic [NUM_SRC-1:0] src_ack;
    logic               cpu_irq;
    logic               cpu_irq_ack;

    modport master (
        output bus_addr, bus_we, src_irq, cpu_irq_ack,
        input  src_ack, cpu_irq
    );

    modport slave (
        input  bus_addr, bus_we, src_irq, cpu_irq_ack,
        output src_ack, cpu_irq
    );
endinterface

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: edge-latched pending bits, software mask,
// fixed priority (index 0 highest), one CPU request line with ack routing and EOI.
module irq_controller #(
    parameter int         NUM_SRC   = 4,
    parameter logic [7:0] BASE_ADDR = 8'hE0
) (
    input  logic             clk,
    input  logic             rst_n,
    irq_controller_if.slave  bus,
    inout  wire [7:0]        bus_data
);
    localparam int W = NUM_SRC;

    typedef enum logic [1:0] {IDLE, RAISE, SERVICE} state_t;

    state_t       state_reg;
    logic [W-1:0] prev_reg;
    logic [W-1:0] pending_reg;
    logic [W-1:0] mask_reg;
    logic [W-1:0] sel_oh_reg;
    logic [W-1:0] src_ack_reg;
    logic [2:0]   sel_idx_reg;
    logic [2:0]   id_idx_reg;
    logic         id_valid_reg;
    logic         cpu_irq_reg;
    logic         oe_reg;
    logic [7:0]   rdata_reg;

    logic [7:0]   offset;
    logic         hit;
    logic         wr;
    logic         rd;
    logic         eoi_wr;
    logic [W-1:0] rise;
    logic [W-1:0] w1c;
    logic [W-1:0] ack_clr;
    logic [W-1:0] pending_next;
    logic [W-1:0] eligible;
    logic [W-1:0] win_oh;
    logic [2:0]   win_idx;
    logic [7:0]   rdata_next;

    // Bits above NUM_SRC are don't-care on writes; EOI ignores the data entirely.
    wire unused_bus = &{1'b0, bus_data};

    always_comb begin
        offset  = bus.bus_addr - BASE_ADDR;
        hit     = (offset[7:2] == 6'd0);
        wr      = hit & bus.bus_we;
        rd      = hit & ~bus.bus_we;
        eoi_wr  = wr && (offset[1:0] == 2'd3);
        rise    = bus.src_irq & ~prev_reg;
        w1c     = (wr && offset[1:0] == 2'd0) ? bus_data[W-1:0] : '0;
        ack_clr = (state_reg == RAISE && bus.cpu_irq_ack) ? sel_oh_reg : '0;
        // A fresh edge beats any clear landing on the same bit in the same cycle.
        pending_next = (pending_reg & ~(w1c | ack_clr)) | rise;
        eligible = pending_reg & mask_reg;

        win_oh  = '0;
        win_idx = 3'd0;
        for (int i = W - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_oh    = '0;
                win_oh[i] = 1'b1;
                win_idx   = 3'(i);
            end
        end

        case (offset[1:0])
            2'd0:    rdata_next = 8'(pending_reg);
            2'd1:    rdata_next = 8'(mask_reg);
            2'd2:    rdata_next = {id_valid_reg, 4'b0000, id_idx_reg};
            default: rdata_next = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            prev_reg     <= '0;
            pending_reg  <= '0;
            mask_reg     <= '0;
            sel_oh_reg   <= '0;
            src_ack_reg  <= '0;
            sel_idx_reg  <= 3'd0;
            id_idx_reg   <= 3'd0;
            id_valid_reg <= 1'b0;
            cpu_irq_reg  <= 1'b0;
            oe_reg       <= 1'b0;
            rdata_reg    <= 8'h00;
        end else begin
            prev_reg    <= bus.src_irq;
            pending_reg <= pending_next;
            if (wr && offset[1:0] == 2'd1) begin
                mask_reg <= bus_data[W-1:0];
            end
            oe_reg <= rd;
            if (rd) begin
                rdata_reg <= rdata_next;
            end
            src_ack_reg <= '0;

            case (state_reg)
                IDLE: begin
                    if (|eligible) begin
                        sel_oh_reg  <= win_oh;
                        sel_idx_reg <= win_idx;
                        cpu_irq_reg <= 1'b1;
                        state_reg   <= RAISE;
                    end
                end
                RAISE: begin
                    // The winner stays latched: mask changes and higher-priority edges do not pre-empt.
                    if (bus.cpu_irq_ack) begin
                        src_ack_reg  <= sel_oh_reg;
                        id_idx_reg   <= sel_idx_reg;
                        id_valid_reg <= 1'b1;
                        cpu_irq_reg  <= 1'b0;
                        state_reg    <= SERVICE;
                    end else if ((pending_next & sel_oh_reg) == '0) begin
                        cpu_irq_reg <= 1'b0;
                        state_reg   <= IDLE;
                    end
                end
                SERVICE: begin
                    if (eoi_wr) begin
                        id_valid_reg <= 1'b0;
                        state_reg    <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.src_ack = src_ack_reg;
    assign bus.cpu_irq = cpu_irq_reg;
    assign bus_data    = oe_reg ? rdata_reg : 8'bz;
endmodule

// File: tb/tb_irq_controller.sv
// Directed scenarios followed by random traffic, every cycle compared against
// a cycle-level behavioural model of the controller's register and request rules.
module tb_irq_controller;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cpu_drive = 1'b0;
    logic [7:0] cpu_wdata = 8'h00;
    logic [3:0] src_lvl = 4'h0;
    logic [7:0] last_rd;
    tri   [7:0] bus_data;

    int checks = 0;
    int failures = 0;
    int n_raise = 0;
    int n_ack0 = 0;
    int n_ack_any = 0;
    bit last_irq = 1'b0;

    // Model: pending/mask as bit sets, a "request raised" flag, a "being serviced" flag.
    bit [3:0] m_prev, m_pend, m_mask, m_ack;
    bit       m_raised, m_serving, m_idv;
    int       m_sel, m_idx;
    bit [7:0] m_rd;

    irq_controller_if #(.NUM_SRC(4)) bus ();

    irq_controller #(.NUM_SRC(4), .BASE_ADDR(8'hE0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .bus_data (bus_data)
    );

    assign bus_data = cpu_drive ? cpu_wdata : 8'bz;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // An undriven net reads as z in a 4-state simulator and as 0 in a 2-state one.
    function automatic bit released();
        return (bus_data === 8'hzz) || (bus_data === 8'h00);
    endfunction

    task automatic model_reset();
        m_prev = '0; m_pend = '0; m_mask = '0; m_ack = '0;
        m_raised = 0; m_serving = 0; m_idv = 0; m_sel = 0; m_idx = 0; m_rd = '0;
    endtask

    task automatic model_step(input int op, input int off, input logic [7:0] data, input logic ack);
        bit [3:0] np;
        int win;
        win = -1;
        case (off)
            0:       m_rd = {4'h0, m_pend};
            1:       m_rd = {4'h0, m_mask};
            2:       m_rd = 8'(m_idv ? 128 : 0) + 8'(m_idx);
            default: m_rd = 8'h00;
        endcase
        np = m_pend;
        for (int i = 0; i < 4; i++) if (op == 1 && off == 0 && data[i]) np[i] = 0;
        if (m_raised && ack) np[m_sel] = 0;
        for (int i = 0; i < 4; i++) if (src_lvl[i] && !m_prev[i]) np[i] = 1;
        m_ack = '0;
        if (!m_raised && !m_serving) begin
            for (int i = 3; i >= 0; i--) if (m_pend[i] && m_mask[i]) win = i;
            if (win >= 0) begin
                m_raised = 1;
                m_sel = win;
            end
        end else if (m_raised) begin
            if (ack) begin
                m_raised = 0; m_serving = 1; m_ack[m_sel] = 1; m_idv = 1; m_idx = m_sel;
            end else if (!np[m_sel]) begin
                m_raised = 0;
            end
        end else if (op == 1 && off == 3) begin
            m_serving = 0;
            m_idv = 0;
        end
        if (op == 1 && off == 1) m_mask = data[3:0];
        m_pend = np;
        m_prev = src_lvl;
    endtask

    // One bus cycle. op: 0 idle, 1 write, 2 read (address phase).
    task automatic cyc(input int op, input int off, input logic [7:0] data, input logic ack);
        bus.bus_addr    = (op == 0) ? 8'h00 : 8'hE0 + 8'(off);
        bus.bus_we      = (op == 1);
        cpu_drive       = (op == 1);
        cpu_wdata       = data;
        bus.src_irq     = src_lvl;
        bus.cpu_irq_ack = ack;
        model_step(op, off, data, ack);
        @(posedge clk); #1;
        chk("cpu_irq", 32'(bus.cpu_irq), 32'(m_raised));
        chk("src_ack", 32'(bus.src_ack), 32'(m_ack));
        if (op == 2) begin
            last_rd = bus_data;
            chk("rd_data", 32'(bus_data), 32'(m_rd));
        end else if (op == 0) begin
            chk("bus_release", 32'(released()), 32'd1);
        end
        if (bus.cpu_irq && !last_irq) n_raise++;
        last_irq = bus.cpu_irq;
        if (bus.src_ack[0]) n_ack0++;
        if (bus.src_ack != 4'h0) n_ack_any++;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 8'h00, 1'b0);
    endtask

    task automatic wr(input int off, input logic [7:0] data);
        cyc(1, off, data, 1'b0);
    endtask

    task automatic rd(input int off);
        cyc(2, off, 8'h00, 1'b0);
        cyc(0, 0, 8'h00, 1'b0);
    endtask

    initial begin
        int r;
        int roff;
        logic rack;
        bus.bus_addr = 8'h00; bus.bus_we = 1'b0; bus.src_irq = 4'h0; bus.cpu_irq_ack = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cpu_irq", 32'(bus.cpu_irq), 32'd0);
        chk("rst_src_ack", 32'(bus.src_ack), 32'd0);
        chk("rst_bus_release", 32'(released()), 32'd1);
        #3 rst_n = 1'b1;
        rd(0); chk("rst_status", 32'(last_rd), 32'h00);
        rd(1); chk("rst_mask", 32'(last_rd), 32'h00);
        rd(2); chk("rst_id", 32'(last_rd), 32'h00);

        // Masked request is latched but not raised until enabled.
        src_lvl = 4'b0001; idle(1);
        src_lvl = 4'b0000; idle(2);
        rd(0); chk("s1_status", 32'(last_rd), 32'h01);
        chk("s1_masked_irq", 32'(bus.cpu_irq), 32'd0);
        wr(1, 8'h01); idle(1);
        chk("s1_irq", 32'(bus.cpu_irq), 32'd1);
        cyc(0, 0, 8'h00, 1'b1);
        wr(3, 8'h00);

        // Simultaneous edges on 1 and 3: priority to 1, then 3 after EOI.
        wr(1, 8'h0F);
        src_lvl = 4'b1010; idle(2);
        chk("s2_irq", 32'(bus.cpu_irq), 32'd1);
        cyc(0, 0, 8'h00, 1'b1);
        chk("s2_src_ack", 32'(bus.src_ack), 32'h2);
        rd(2); chk("s2_id", 32'(last_rd), 32'h81);
        rd(0); chk("s2_status", 32'(last_rd), 32'h08);
        wr(3, 8'h5A);
        rd(2); chk("s3_id_after_eoi", 32'(last_rd), 32'h01);
        chk("s3_irq", 32'(bus.cpu_irq), 32'd1);
        cyc(0, 0, 8'h00, 1'b1);
        chk("s3_src_ack", 32'(bus.src_ack), 32'h8);
        rd(2); chk("s3_id", 32'(last_rd), 32'h83);
        wr(3, 8'h00);
        src_lvl = 4'b0000; idle(1);

        // Withdraw by W1C while raised.
        src_lvl = 4'b0100; idle(1);
        src_lvl = 4'b0000; idle(1);
        chk("s4_irq", 32'(bus.cpu_irq), 32'd1);
        n_ack_any = 0;
        wr(0, 8'h04);
        chk("s4_drop", 32'(bus.cpu_irq), 32'd0);
        idle(4);
        chk("s4_no_ack", 32'(n_ack_any), 32'd0);

        // Level held high for 100 cycles yields one raise and one ack.
        n_raise = 0; n_ack0 = 0;
        src_lvl = 4'b0001;
        for (int i = 0; i < 100; i++) begin
            if (i == 10) cyc(0, 0, 8'h00, 1'b1);
            else if (i == 30) wr(3, 8'h00);
            else if (i == 50) begin
                rd(1);
                chk("s5_mask_rd", 32'(last_rd), 32'h0F);
            end else idle(1);
        end
        chk("s5_raise_count", 32'(n_raise), 32'd1);
        chk("s5_ack_count", 32'(n_ack0), 32'd1);
        src_lvl = 4'b0000; idle(1);

        // Asynchronous reset while the ack pulse is high.
        src_lvl = 4'b0101; idle(1);
        src_lvl = 4'b0000; idle(1);
        cyc(0, 0, 8'h00, 1'b1);
        chk("s6_ack_high", 32'(bus.src_ack), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("s6_rst_src_ack", 32'(bus.src_ack), 32'd0);
        chk("s6_rst_cpu_irq", 32'(bus.cpu_irq), 32'd0);
        chk("s6_rst_pending", 32'(dut.pending_reg), 32'd0);
        chk("s6_rst_mask", 32'(dut.mask_reg), 32'd0);
        model_reset();
        last_irq = 1'b0;
        #4 rst_n = 1'b1;
        rd(1); chk("s6_mask_rd", 32'(last_rd), 32'h00);
        rd(0); chk("s6_status_rd", 32'(last_rd), 32'h00);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) src_lvl = 4'($urandom);
            r    = int'($urandom_range(0, 99));
            roff = int'($urandom_range(0, 3));
            rack = ($urandom_range(0, 3) == 0);
            if (r < 10)      cyc(1, 1, 8'($urandom), rack);
            else if (r < 20) cyc(1, 0, 8'($urandom), rack);
            else if (r < 26) cyc(1, 3, 8'($urandom), rack);
            else if (r < 29) cyc(1, 2, 8'($urandom), rack);
            else if (r < 42) begin
                cyc(2, roff, 8'h00, rack);
                cyc(0, 0, 8'h00, 1'b0);
            end else cyc(0, 0, 8'h00, rack);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
